// File: rtl/uart_tx.sv
// =============================================================================
// Module   : uart_tx
// Brief    : 8N1 serial transmitter, LSB first, idle-high line, start/ready
//            handshake. Define UART_TX_PARITY_EN for an 8E1 frame.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module uart_tx #(
    parameter int BAUDRATE = 104
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int c_cnt_w = $clog2(BAUDRATE);
`ifdef UART_TX_PARITY_EN
    localparam int c_frame_bits = 11;
`else
    localparam int c_frame_bits = 10;
`endif
    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(BAUDRATE - 1);
    localparam logic [3:0]         c_last_bit  = 4'(c_frame_bits - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_TRANS = 1'b1;

    logic [0:0]              r_state;
    logic [c_frame_bits-1:0] r_shift;
    logic [c_cnt_w-1:0]      r_baud_cnt;
    logic [3:0]              r_bit_cnt;
    logic                    r_ready;
    logic [c_frame_bits-1:0] w_frame;
    logic                    w_tick;

`ifdef UART_TX_PARITY_EN
    assign w_frame = {1'b1, ^data, data, 1'b0};
`else
    assign w_frame = {1'b1, data, 1'b0};
`endif

    assign w_tick = (r_state == S_TRANS) && (r_baud_cnt == c_baud_last);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_shift    <= '1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_ready    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift    <= w_frame;
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_ready    <= 1'b0;
                        r_state    <= S_TRANS;
                    end
                end
                S_TRANS: begin
                    if (w_tick) begin
                        // Shifting in ones leaves the line idle once the stop bit is out.
                        r_baud_cnt <= '0;
                        r_shift    <= {1'b1, r_shift[c_frame_bits-1:1]};
                        r_bit_cnt  <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == c_last_bit) begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // The line comes straight off a flop, so it never glitches.
    assign tx    = r_shift[0];
    assign ready = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// =============================================================================
// Module   : tb_uart_tx
// Brief    : Scoreboard bench for uart_tx: stimulus queues expected frames,
//            a line monitor decodes tx and compares.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_uart_tx;

    localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    typedef struct packed {
        logic       abort;
        logic       par;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [7:0] data;
    logic       tx;
    logic       ready;

    exp_t sb[$];
    int   falls[$];
    int   errors = 0;
    int   checks = 0;
    int   frames_done = 0;
    int   frames_expected = 0;

    uart_tx #(.BAUDRATE(BAUD)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .data  (data),
        .tx    (tx),
        .ready (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input bit ok,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic       prev_ready;
        logic       rst_edge;
        bit         in_frame;
        bit         glitch;
        bit         ok;
        int         cyc;
        int         lowcnt;
        int         cycle;
        logic       vals[FRAME];
        logic [7:0] got;
        exp_t       e;
        prev_ready = 1'b1;
        in_frame   = 0;
        glitch     = 0;
        cyc        = 0;
        lowcnt     = 0;
        cycle      = 0;
        forever begin
            @(posedge clk);
            rst_edge = !rstn;
            #1;
            cycle++;
            if (rst_edge) begin
                check("reset_outputs", tx === 1'b1 && ready === 1'b1, {30'd0, tx, ready}, 32'h3);
                if (in_frame) begin
                    if (sb.size() == 0) begin
                        check("abort_unexpected", 1'b0, 32'd0, 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check("abort_expected", e.abort == 1'b1, {31'd0, e.abort}, 32'd1);
                    end
                    in_frame = 0;
                end
                lowcnt = 0;
            end else begin
                if (!in_frame && tx === 1'b0) begin
                    in_frame = 1;
                    cyc      = 0;
                    glitch   = 0;
                    falls.push_back(cycle);
                    check("start_align", prev_ready === 1'b1 && ready === 1'b0,
                          {30'd0, prev_ready, ready}, 32'h2);
                end
                if (in_frame) begin
                    if (cyc % BAUD == 0) vals[cyc / BAUD] = tx;
                    else if (tx !== vals[cyc / BAUD]) glitch = 1;
                    cyc++;
                    if (cyc == FRAME * BAUD) begin
                        in_frame = 0;
                        frames_done++;
                        for (int i = 0; i < 8; i++) got[i] = vals[i + 1];
                        if (sb.size() == 0) begin
                            check("unexpected_frame", 1'b0, {24'd0, got}, 32'd0);
                        end else begin
                            e = sb.pop_front();
                            check("frame_data", got === e.data && !e.abort, {24'd0, got}, {24'd0, e.data});
                            ok = (vals[0] === 1'b0) && (vals[FRAME-1] === 1'b1) && !glitch;
`ifdef UART_TX_PARITY_EN
                            ok = ok && (vals[9] === e.par);
`endif
                            check("frame_shape", ok,
                                  {29'd0, glitch, vals[0], vals[FRAME-1]}, 32'h1);
                        end
                    end
                end
                if (ready === 1'b0) begin
                    lowcnt++;
                end else if (lowcnt != 0) begin
                    check("busy_len", lowcnt == FRAME * BAUD, lowcnt, FRAME * BAUD);
                    lowcnt = 0;
                end
            end
            prev_ready = ready;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        bit seen;
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("ready_timeout", 1'b0, 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic p, input logic ab);
        wait_ready();
        start = 1'b1;
        data  = d;
        sb.push_back('{abort: ab, par: p, data: d});
        if (!ab) frames_expected++;
        @(negedge clk);
        start = 1'b0;
        data  = ~d;
    endtask

    task automatic wait_drained();
        bit done;
        done = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && ready === 1'b1) begin
                done = 1;
                break;
            end
        end
        if (!done) check("drain_timeout", 1'b0, sb.size(), 32'd0);
    endtask

    initial begin
        int diff;
        rstn  = 1'b0;
        start = 1'b1;
        data  = 8'h5A;
        // Reset held with start asserted; no frame may begin.
        repeat (3) @(negedge clk);
        rstn  = 1'b1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_after_reset", tx === 1'b1 && ready === 1'b1, {30'd0, tx, ready}, 32'h3);

        // Single frame.
        send(8'h55, 1'b0, 1'b0);
        wait_drained();

        // Back-to-back with start held high.
        falls.delete();
        wait_ready();
        start = 1'b1;
        data  = 8'hA3;
        sb.push_back('{abort: 1'b0, par: 1'b0, data: 8'hA3});
        frames_expected++;
        @(negedge clk);
        data = 8'h0F;
        wait_ready();
        sb.push_back('{abort: 1'b0, par: 1'b0, data: 8'h0F});
        frames_expected++;
        @(negedge clk);
        start = 1'b0;
        data  = 8'h77;
        wait_drained();
        diff = (falls.size() >= 2) ? (falls[1] - falls[0]) : -1;
        check("b2b_spacing", diff == FRAME * BAUD + 1, diff, FRAME * BAUD + 1);

        // Busy rejection.
        send(8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            data  = 8'hFF;
            @(negedge clk);
            start = 1'b0;
        end
        wait_drained();
        repeat (60) @(negedge clk);

        // Mid-frame reset, then a clean frame.
        send(8'h00, 1'b0, 1'b1);
        repeat (15) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        send(8'hC5, 1'b0, 1'b0);
        wait_drained();

`ifdef UART_TX_PARITY_EN
        send(8'h07, 1'b1, 1'b0);
        wait_drained();
        send(8'h03, 1'b0, 1'b0);
        wait_drained();
`endif

        repeat (60) @(negedge clk);
        check("frame_count", frames_done == frames_expected, frames_done, frames_expected);
        check("sb_empty", sb.size() == 0, sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
